// File: rtl/inventory_dispense_controller.sv
// inventory_dispense_controller
// Holds the four per-item stock counters that feed the vending state machine,
// accepts vend requests (rising edges of the FSM decrement level) and service
// restock requests, and runs one dispense motor for a fixed time per vend.
//
// Ports
//   clk_i            system clock, rising edge
//   reset_i          synchronous active-high reset
//   vend_req_i       vend level from the FSM; only rising edges count
//   item_code_i      item code, captured on a vend_req_i rising edge
//   restock_req_i    service restock request level
//   restock_slot_i   slot to restock (0 chips, 1 candy, 2 soda, 3 cookie)
//   restock_qty_i    units to add, saturating at 7
//   cs_pc_o..cs_c_o  stock counts for slots 0..3
//   motor_o          one-hot motor drive, bit index = slot
//   vend_ack_o       1-cycle pulse, vend accepted and counter decremented
//   vend_err_o       1-cycle pulse, vend rejected or dropped
//   restock_ack_o    1-cycle pulse, restock applied
//   busy_o           high whenever the controller is not idle
module inventory_dispense_controller #(
  parameter int         MOTOR_CYCLES = 50_000_000,
  parameter logic [2:0] INIT_STOCK   = 3'd5
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       vend_req_i,
  input  logic [7:0] item_code_i,
  input  logic       restock_req_i,
  input  logic [1:0] restock_slot_i,
  input  logic [2:0] restock_qty_i,
  output logic [2:0] cs_pc_o,
  output logic [2:0] cs_cb_o,
  output logic [2:0] cs_s_o,
  output logic [2:0] cs_c_o,
  output logic [3:0] motor_o,
  output logic       vend_ack_o,
  output logic       vend_err_o,
  output logic       restock_ack_o,
  output logic       busy_o
);

  localparam int            TW         = (MOTOR_CYCLES > 2) ? $clog2(MOTOR_CYCLES) : 1;
  localparam logic [TW-1:0] TIMER_LAST = TW'(MOTOR_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, DISPENSE, RESTOCK} state_e;

  state_e        state_q, state_d;
  logic [2:0]    cnt_q [4];
  logic [2:0]    cnt_d [4];
  logic [3:0]    motor_q, motor_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          vend_req_q;
  logic          pend_valid_q, pend_valid_d;
  logic [7:0]    pend_code_q, pend_code_d;
  logic          restock_armed_q, restock_armed_d;
  logic          vend_ack_q, vend_ack_d;
  logic          vend_err_q, vend_err_d;
  logic          restock_ack_q, restock_ack_d;

  logic          vend_edge;
  logic [7:0]    sel_code;
  logic          dec_valid;
  logic [1:0]    dec_slot;
  logic [3:0]    restock_sum;

  assign vend_edge = vend_req_i & ~vend_req_q;

  // A waiting pending vend always takes precedence over a fresh edge in IDLE.
  always_comb begin
    sel_code  = pend_valid_q ? pend_code_q : item_code_i;
    dec_valid = 1'b1;
    dec_slot  = 2'd0;
    case (sel_code)
      8'hA2:   dec_slot = 2'd0;
      8'hB3:   dec_slot = 2'd1;
      8'hD5:   dec_slot = 2'd2;
      8'hE8:   dec_slot = 2'd3;
      default: dec_valid = 1'b0;
    endcase
  end

  // 4-bit sum so an overflow past 7 can be detected and saturated.
  assign restock_sum = {1'b0, cnt_q[restock_slot_i]} + {1'b0, restock_qty_i};

  always_comb begin
    state_d         = state_q;
    cnt_d           = cnt_q;
    motor_d         = motor_q;
    timer_d         = timer_q;
    pend_valid_d    = pend_valid_q;
    pend_code_d     = pend_code_q;
    restock_armed_d = restock_armed_q | ~restock_req_i;
    vend_ack_d      = 1'b0;
    vend_err_d      = 1'b0;
    restock_ack_d   = 1'b0;

    case (state_q)
      IDLE: begin
        if (pend_valid_q || vend_edge) begin
          // Consuming the pending slot frees it, so a coincident new edge
          // takes its place instead of being dropped.
          pend_valid_d = pend_valid_q & vend_edge;
          if (pend_valid_q && vend_edge) begin
            pend_code_d = item_code_i;
          end
          if (!dec_valid || cnt_q[dec_slot] == 3'd0) begin
            vend_err_d = 1'b1;
          end else begin
            cnt_d[dec_slot] = cnt_q[dec_slot] - 3'd1;
            vend_ack_d      = 1'b1;
            motor_d         = 4'b0001 << dec_slot;
            timer_d         = '0;
            state_d         = DISPENSE;
          end
        end else if (restock_req_i && restock_armed_q) begin
          restock_armed_d = 1'b0;
          state_d         = RESTOCK;
        end
      end
      DISPENSE: begin
        // The accept edge already started the first motor cycle.
        if (timer_q == TIMER_LAST) begin
          motor_d = 4'b0000;
          state_d = IDLE;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      RESTOCK: begin
        cnt_d[restock_slot_i] = restock_sum[3] ? 3'd7 : restock_sum[2:0];
        restock_ack_d         = 1'b1;
        state_d               = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (state_q != IDLE && vend_edge) begin
      if (!pend_valid_q) begin
        pend_valid_d = 1'b1;
        pend_code_d  = item_code_i;
      end else begin
        vend_err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q         <= IDLE;
      for (int i = 0; i < 4; i++) begin
        cnt_q[i] <= INIT_STOCK;
      end
      motor_q         <= 4'b0000;
      timer_q         <= '0;
      vend_req_q      <= 1'b0;
      pend_valid_q    <= 1'b0;
      pend_code_q     <= 8'h00;
      restock_armed_q <= 1'b1;
      vend_ack_q      <= 1'b0;
      vend_err_q      <= 1'b0;
      restock_ack_q   <= 1'b0;
    end else begin
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      motor_q         <= motor_d;
      timer_q         <= timer_d;
      vend_req_q      <= vend_req_i;
      pend_valid_q    <= pend_valid_d;
      pend_code_q     <= pend_code_d;
      restock_armed_q <= restock_armed_d;
      vend_ack_q      <= vend_ack_d;
      vend_err_q      <= vend_err_d;
      restock_ack_q   <= restock_ack_d;
    end
  end

  assign cs_pc_o       = cnt_q[0];
  assign cs_cb_o       = cnt_q[1];
  assign cs_s_o        = cnt_q[2];
  assign cs_c_o        = cnt_q[3];
  assign motor_o       = motor_q;
  assign vend_ack_o    = vend_ack_q;
  assign vend_err_o    = vend_err_q;
  assign restock_ack_o = restock_ack_q;
  assign busy_o        = (state_q != IDLE);

endmodule

// File: doc/inventory_dispense_controller.md
Name: inventory_dispense_controller

Overview:
- Owns the four per-item stock counters and drives the `cs_pc`, `cs_cb`, `cs_s` and `cs_c` stock-count inputs of the vending state machine.
- Sequences one dispense motor per accepted vend.
- Arbitrates the single counter-update path between vend requests from the vending FSM (its `decrement` and `item_code`) and restock requests from the service port.
- Sits between the vending FSM and the motor drivers.

Parameters:
- MOTOR_CYCLES, 50_000_000: number of clk cycles a motor output stays high per dispense (1 s at 50 MHz). Must be ≥ 2.
- INIT_STOCK, 3'd5: value loaded into every stock counter on reset.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- vend_req  input  1  level from the FSM `decrement`; may stay high for several cycles; only rising edges count.
- item_code  input  8  item code, sampled on a vend_req rising edge.
- restock_req  input  1  service restock request, level.
- restock_slot  input  2  slot to restock: 0 = chips, 1 = candy, 2 = soda, 3 = cookie.
- restock_qty  input  3  units to add.
- cs_pc  output  3  potato-chip stock (slot 0).
- cs_cb  output  3  candy-bar stock (slot 1).
- cs_s  output  3  soda stock (slot 2).
- cs_c  output  3  cookie stock (slot 3).
- motor  output  4  one-hot dispense motor drive, bit = slot.
- vend_ack  output  1  1-cycle pulse: vend accepted and counter decremented.
- vend_err  output  1  1-cycle pulse: vend rejected.
- restock_ack  output  1  1-cycle pulse: restock applied.
- busy  output  1  high whenever state ≠ IDLE.

Behaviour:
- **Reset** (synchronous, wins over everything):
  - all counters = INIT_STOCK, motor = 0, all acks/err = 0, busy = 0.
  - state = IDLE, pending cleared, edge register cleared, restock_armed = 1.
  - Reset during DISPENSE drops the motor at the next edge; no count is restored beyond INIT_STOCK.
- **Code decode:**
  - 8'hA2 → slot 0, 8'hB3 → slot 1, 8'hD5 → slot 2, 8'hE8 → slot 3.
  - Any other code is invalid.
- **Edge detect:**
  - vend_edge = vend_req & ~vend_req_q, where vend_req_q is registered every cycle.
  - item_code is captured on the edge cycle.
- **Pending:**
  - One-deep register {valid, code}.
  - A vend_edge while state ≠ IDLE loads pending if it is empty.
  - If pending is already full, the edge is dropped and vend_err pulses the next cycle.
- **States:** IDLE, DISPENSE, RESTOCK.
- **IDLE:**
  - Priority is pending vend > new vend_edge > restock.
  - A vend with an invalid code, or a zero count for its slot:
    - vend_err = 1 for one cycle, stay IDLE, counters unchanged.
    - pending is cleared if it was the source.
  - A valid vend with count > 0, applied at that edge:
    - count[slot] -= 1, vend_ack = 1 for one cycle.
    - motor = one-hot(slot), motor timer = 0, state → DISPENSE.
  - Restock fires when there is no vend this cycle, restock_req = 1 and restock_armed = 1:
    - state → RESTOCK, restock_armed = 0.
- **DISPENSE:**
  - The timer increments each cycle.
  - motor stays high exactly MOTOR_CYCLES cycles in total, counting from the accept edge.
  - Then motor = 0 and state → IDLE.
  - A pending vend is serviced on the first IDLE cycle, so there is a 1-cycle motor gap between back-to-back dispenses.
- **RESTOCK (one cycle):**
  - count[restock_slot] = min(count + restock_qty, 7): 4-bit sum saturated to 3'd7, never wraps.
  - restock_ack = 1 for one cycle, state → IDLE.
- **Re-arm:** restock_armed returns to 1 only after restock_req is sampled low. A request held high is applied exactly once.
- **Simultaneous events:**
  - A vend_edge and restock_req in the same IDLE cycle: the vend wins; the restock waits, still armed.
  - restock_qty = 0: restock_ack still pulses, count unchanged.
- **Outputs:** all outputs are registered. busy = (state ≠ IDLE). cs_* reflect the counters directly.
- **Size estimate:** about 200 lines RTL.

Test Plan (MOTOR_CYCLES = 4 override):
- **Reset values:** reset 2 cycles → cs_pc = cs_cb = cs_s = cs_c = 5, motor = 0, busy = 0, no pulses.
- **Valid vend, level held:** item_code = A2, vend_req high for 3 cycles → vend_ack once, cs_pc = 4, motor = 4'b0001 for exactly 4 cycles, busy high 4 cycles, single decrement only.
- **Invalid code, empty slot:**
  - item_code = 8'h11 edge → vend_err one pulse, no motor, counts unchanged.
  - cookie count driven to 0 via 5 vends, then a 6th E8 vend → vend_err, cs_c stays 0.
- **Queued and dropped vends:**
  - B3 vend, then a D5 edge during DISPENSE → D5 serviced in the first IDLE cycle, motor 0010, gap, then 0100.
  - A third edge during DISPENSE with pending full → vend_err, dropped.
- **Restock saturation and re-arm:** slot 2 at 5, restock_qty = 6, restock_req held 10 cycles → one restock_ack, cs_s = 7. Drop the request, reassert with qty 0 → ack, cs_s = 7.
- **Vend vs restock collision, reset mid-dispense:**
  - vend_edge (A2) and restock_req (slot 0, qty 2) in the same cycle → vend first (cs_pc 5→4), then restock after DISPENSE (→6).
  - reset asserted in DISPENSE cycle 2 → motor = 0 next cycle, counts = 5.
